// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, stall/flush control and shadow pipeline tracking
// Tracks ID/EX, EX/LS and LS/WB occupancy and resolves load-use, branch and memory-stall hazards.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       ifidValid,
    input  logic [4:0] ifidRs1,
    input  logic [4:0] ifidRs2,
    input  logic       ifidRs1able,
    input  logic       ifidRs2able,
    input  logic [4:0] ifidRd,
    input  logic       ifidwreg,
    input  logic       ifidload,
    input  logic       ifidmem,
    input  logic       exBranchTaken,
    input  logic       memDone,
    output logic       stallIF,
    output logic       stallID,
    output logic       flushIFID,
    output logic       loadused,
    output logic [4:0] idexRs1,
    output logic [4:0] idexRs2,
    output logic       idexRs1able,
    output logic       idexRs2able,
    output logic [4:0] exlsRd,
    output logic       exlswreg,
    output logic [4:0] lswbRd,
    output logic       lswbwreg,
    output logic       memTimeout
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1able;
        logic       rs2able;
        logic [4:0] rd;
        logic       wreg;
        logic       load;
        logic       mem;
    } idex_t;

    // Later stages keep only the fields that something downstream still observes.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wreg;
        logic       mem;
    } exls_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wreg;
    } lswb_t;

    typedef enum logic [1:0] {
        ADV_NORMAL,
        ADV_LOAD_USE,
        ADV_BRANCH,
        ADV_MEM_HOLD
    } adv_e;

    idex_t      idex_q, idex_d;
    exls_t      exls_q, exls_d;
    lswb_t      lswb_q, lswb_d;
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;

    logic       ls_stall;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_hazard;
    logic       load_use;
    adv_e       action;

    always_comb begin
        ls_stall    = exls_q.valid & exls_q.mem & ~memDone;
        rs1_hit     = (idex_q.rd == ifidRs1) & ifidRs1able;
        rs2_hit     = (idex_q.rd == ifidRs2) & ifidRs2able;
        load_hazard = ifidValid & idex_q.valid & idex_q.load & idex_q.wreg
                    & (idex_q.rd != 5'd0) & (rs1_hit | rs2_hit);
        load_use    = load_hazard & ~ls_stall & ~exBranchTaken;

        if (ls_stall) begin
            action = ADV_MEM_HOLD;
        end else if (exBranchTaken) begin
            action = ADV_BRANCH;
        end else if (load_use) begin
            action = ADV_LOAD_USE;
        end else begin
            action = ADV_NORMAL;
        end
    end

    always_comb begin
        idex_d = idex_q;
        exls_d = exls_q;
        lswb_d = lswb_q;

        case (action)
            ADV_MEM_HOLD: begin
                lswb_d = '0;
            end
            ADV_BRANCH, ADV_LOAD_USE: begin
                idex_d = '0;
                exls_d = '{valid: idex_q.valid, rd: idex_q.rd, wreg: idex_q.wreg, mem: idex_q.mem};
                lswb_d = '{valid: exls_q.valid, rd: exls_q.rd, wreg: exls_q.wreg};
            end
            default: begin
                idex_d = '{valid:   ifidValid,
                           rs1:     ifidRs1,
                           rs2:     ifidRs2,
                           rs1able: ifidRs1able,
                           rs2able: ifidRs2able,
                           rd:      ifidRd,
                           wreg:    ifidwreg,
                           load:    ifidload,
                           mem:     ifidmem};
                exls_d = '{valid: idex_q.valid, rd: idex_q.rd, wreg: idex_q.wreg, mem: idex_q.mem};
                lswb_d = '{valid: exls_q.valid, rd: exls_q.rd, wreg: exls_q.wreg};
            end
        endcase
    end

    // Watchdog counts consecutive LS-stall cycles; the timeout flag is sticky.
    always_comb begin
        wdog_d = 8'd0;
        if (ls_stall) begin
            wdog_d = (wdog_q == 8'hFF) ? 8'hFF : wdog_q + 8'd1;
        end
        timeout_d = timeout_q | (wdog_d == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q    <= '0;
            exls_q    <= '0;
            lswb_q    <= '0;
            wdog_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            idex_q    <= idex_d;
            exls_q    <= exls_d;
            lswb_q    <= lswb_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    // Every output is forced low while reset is held, including the combinational controls.
    logic idex_live;
    logic exls_live;
    logic lswb_live;

    always_comb begin
        idex_live   = ~rst & idex_q.valid;
        exls_live   = ~rst & exls_q.valid;
        lswb_live   = ~rst & lswb_q.valid;

        stallIF     = ~rst & (ls_stall | load_use);
        stallID     = ~rst & (ls_stall | load_use);
        flushIFID   = ~rst & ~ls_stall & exBranchTaken;
        loadused    = ~rst & load_use;

        idexRs1     = idex_live ? idex_q.rs1 : 5'd0;
        idexRs2     = idex_live ? idex_q.rs2 : 5'd0;
        idexRs1able = idex_live & idex_q.rs1able;
        idexRs2able = idex_live & idex_q.rs2able;
        exlsRd      = exls_live ? exls_q.rd : 5'd0;
        exlswreg    = exls_live & exls_q.wreg;
        lswbRd      = lswb_live ? lswb_q.rd : 5'd0;
        lswbwreg    = lswb_live & lswb_q.wreg;
        memTimeout  = ~rst & timeout_q;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have clock port clk: input, 1 bit, single clock; all state updates on its rising edge.
REQ-002 SHALL have reset port rst: input, 1 bit, synchronous, active-high.
REQ-003 SHALL have decode-stage inputs:
  - ifidValid, in, 1: IF/ID holds a real instruction.
  - ifidRs1, ifidRs2, in, 5 each: source register numbers.
  - ifidRs1able, ifidRs2able, in, 1 each: the instruction actually reads that source.
  - ifidRd, in, 5: destination register number.
  - ifidwreg, in, 1: the instruction writes rd.
  - ifidload, in, 1: the instruction is a load.
  - ifidmem, in, 1: the instruction is a load or store.
REQ-004 SHALL have exBranchTaken, in, 1: the instruction in EX redirects the PC.
REQ-005 SHALL have memDone, in, 1: the LSU completed the access of the instruction in LS this cycle.
REQ-006 SHALL have stall outputs stallIF and stallID (out, 1 each): hold the PC and hold IF/ID.
REQ-007 SHALL have flushIFID (out, 1): squash IF/ID.
REQ-008 SHALL have loadused (out, 1): a load-use bubble is being inserted this cycle.
REQ-009 SHALL have ID/EX tracking outputs (out): idexRs1 and idexRs2 (5 each), idexRs1able and idexRs2able (1 each).
REQ-010 SHALL have later-stage tracking outputs (out): exlsRd (5), exlswreg (1), lswbRd (5), lswbwreg (1).
REQ-011 SHALL have memTimeout (out, 1): sticky LS-stall watchdog flag.

Function
REQ-012 SHALL keep a shadow pipeline of three stage registers: ID/EX, EX/LS and LS/WB.
  - Each stage stores valid, rs1, rs2, rs1able, rs2able, rd, wreg, load and mem.
  - A stage's outputs SHALL read as 0 whenever its valid bit is 0.
REQ-013 SHALL compute lsStall combinationally: EX/LS valid AND EX/LS mem AND NOT memDone.
REQ-014 SHALL compute loadused combinationally as the AND of all of the following:
  - ifidValid, ID/EX valid, ID/EX load, ID/EX wreg, ID/EX rd != 0.
  - (ID/EX rd == ifidRs1 AND ifidRs1able) OR (ID/EX rd == ifidRs2 AND ifidRs2able).
  - NOT lsStall, NOT exBranchTaken.
REQ-015 SHALL apply priority lsStall > exBranchTaken > loadused > normal advance.
REQ-016 On lsStall SHALL:
  - Hold ID/EX and EX/LS.
  - Load a bubble (valid=0) into LS/WB.
  - Drive stallIF=stallID=1 and flushIFID=0.
REQ-017 On exBranchTaken without lsStall SHALL:
  - Drive flushIFID=1 and stallIF=stallID=0.
  - Load a bubble into ID/EX.
  - Advance ID/EX to EX/LS and EX/LS to LS/WB.
REQ-018 On loadused SHALL:
  - Drive stallIF=stallID=1.
  - Load a bubble into ID/EX.
  - Advance ID/EX to EX/LS and EX/LS to LS/WB.
  - The stall SHALL last exactly one cycle, since the load leaves ID/EX on that edge.
REQ-019 On normal advance SHALL:
  - Capture the IF/ID fields into ID/EX, with valid=ifidValid.
  - Shift ID/EX to EX/LS and EX/LS to LS/WB.
  - Drive stallIF, stallID and flushIFID to 0.
REQ-020 SHALL run the watchdog as an 8-bit counter:
  - Increments each lsStall cycle, saturating at 255.
  - Clears on any cycle without lsStall.
  - memTimeout SHALL set on the edge the counter reaches 255 and stay set until rst.
REQ-021 exBranchTaken during lsStall SHALL be ignored: ID/EX is held, so EX re-asserts it after the stall releases.
REQ-022 A load whose rd is x0 SHALL never cause loadused.

Reset
REQ-023 While rst=1 at a clock edge SHALL:
  - Clear every stage's valid bit and all stored fields to 0.
  - Clear the watchdog counter and memTimeout to 0.
REQ-024 While rst=1 SHALL drive all outputs to 0.
  - This includes stallIF, stallID, flushIFID and loadused, which are forced to 0 despite being combinational.
REQ-025 Reset asserted mid-stall SHALL take priority over all hazard logic.
  - The first cycle after rst deasserts SHALL behave as an empty pipeline.

Verification
REQ-026 Load-use hazard:
  - Stimulus: load x5 advanced into ID/EX; next cycle ifidRs1=5, ifidRs1able=1.
  - Response: loadused=stallIF=stallID=1 for exactly 1 cycle; idexRs1 reads 0 (bubble) the cycle after; consumer enters ID/EX one cycle later.
REQ-027 Loads that must not stall:
  - Load x0 followed by a consumer of x0 -> loadused=0.
  - Load x5 followed by a consumer with ifidRs1=5 but ifidRs1able=0 -> loadused=0.
REQ-028 Memory stall:
  - Stimulus: store in EX/LS, memDone=0 for 3 cycles, then 1.
  - Response: stallIF=stallID=1 for 3 cycles; lswbwreg=0 during the stall; the store reaches LS/WB on the edge where memDone=1.
REQ-029 Simultaneous events:
  - exBranchTaken and a load-use condition together -> flushIFID=1, loadused=0.
  - exBranchTaken during lsStall -> flushIFID=0.
REQ-030 Watchdog:
  - memDone held 0 for 255 cycles -> memTimeout rises, then stays 1 after memDone=1.
  - rst -> memTimeout=0.
REQ-031 Forwarding fields:
  - Stimulus: back-to-back ALU writes to x3 then x4.
  - Response: the cycle after the second enters EX/LS, exlsRd=4, exlswreg=1, lswbRd=3, lswbwreg=1.
